// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-addressed data SRAM.
// Converts byte-addressed, sized CPU accesses into single-word memory
// accesses. Sub-word stores use read-modify-write, and sub-word loads
// extract one lane and sign- or zero-extend it. Misaligned requests are
// rejected without touching memory.
module load_store_unit #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misaligned,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RMW_READ,
    S_RMW_WRITE,
    S_DONE
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e              state_q, state_d;
  logic                write_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [ADDR_W+1:0]   addr_q;     // word address plus byte-lane bits
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;    // word returned by the memory read
  logic                misaligned_q;

  logic                accept;
  logic                req_misaligned;
  logic [DATA_W-1:0]   merged_word;
  logic [DATA_W-1:0]   load_data;
  logic [7:0]          lane_byte;
  logic [15:0]         lane_half;

  // High address bits are ignored: the address space wraps at the SRAM size.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Halfwords need an even address, words a 4-byte aligned one, size 11 is never legal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lane[0];
      SZ_WORD: is_misaligned = |lane;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  assign req_ready      = (state_q == S_IDLE) && reset;
  assign accept         = (state_q == S_IDLE) && req_valid;
  assign req_misaligned = is_misaligned(req_size, req_addr[1:0]);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture on accept and memory read-data capture on the edge leaving a read state.
  // NOTE: datapath registers are reset as well; outputs are state-gated anyway, this only keeps X out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      if (accept) begin
        write_q      <= req_write;
        size_q       <= req_size;
        signed_q     <= req_signed;
        addr_q       <= req_addr[ADDR_W+1:0];
        wdata_q      <= req_wdata;
        misaligned_q <= req_misaligned;
      end
      if (state_q == S_READ || state_q == S_RMW_READ) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Next-state decode.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_misaligned)         state_d = S_DONE;
          else if (!req_write)        state_d = S_READ;
          else if (req_size == SZ_WORD) state_d = S_WRITE;
          else                        state_d = S_RMW_READ;
        end
      end
      S_READ:      state_d = S_DONE;
      S_WRITE:     state_d = S_DONE;
      S_RMW_READ:  state_d = S_RMW_WRITE;
      S_RMW_WRITE: state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Lane merge for sub-word stores and lane extraction for sub-word loads (little-endian).
  always_comb begin
    merged_word = rdata_q;
    if (size_q == SZ_BYTE) begin
      merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
    lane_byte = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    lane_half = rdata_q[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: load_data = {{24{signed_q & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_data = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_data = rdata_q;
    endcase
  end

  // Outputs decoded from the current state and the latched request only.
  always_comb begin
    resp_valid      = (state_q == S_DONE);
    resp_misaligned = (state_q == S_DONE) && misaligned_q;
    resp_rdata      = '0;
    if (state_q == S_DONE && !write_q && !misaligned_q) begin
      resp_rdata = load_data;
    end
    mem_read    = (state_q == S_READ) || (state_q == S_RMW_READ);
    mem_write   = (state_q == S_WRITE) || (state_q == S_RMW_WRITE);
    mem_address = (state_q != S_IDLE) ? addr_q[ADDR_W+1:2] : '0;
    mem_wdata   = '0;
    if (state_q == S_WRITE) begin
      mem_wdata = wdata_q;
    end else if (state_q == S_RMW_WRITE) begin
      mem_wdata = merged_word;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver pushes expected responses
// and memory writes into queues; a negedge monitor pops and compares.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        mem_read;
  logic        mem_write;
  logic [10:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read, synchronous-write SRAM model.
  logic [31:0] mem [0:2047];
  assign mem_rdata = mem[mem_address];
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_wdata;

  typedef struct { logic [31:0] rdata; logic mis; int cyc; } resp_t;
  typedef struct { logic [10:0] addr; logic [31:0] data; } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    reads_seen = 0;
  int    exp_reads = 0;
  bit    both_hi = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: counts cycles, compares memory writes and responses against the queues.
  always @(negedge clk) begin
    cyc++;
    if (mem_read && mem_write) both_hi = 1'b1;
    if (mem_read) reads_seen++;
    if (mem_write) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_write: addr %h data %h with nothing expected", mem_address, mem_wdata);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("write_addr", 32'(mem_address), 32'(w.addr));
        check("write_data", mem_wdata, w.data);
      end
    end
    if (resp_valid) begin
      if (resp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_resp: rdata %h mis %b with nothing expected", resp_rdata, resp_misaligned);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check("resp_rdata", resp_rdata, r.rdata);
        check("resp_misaligned", 32'(resp_misaligned), 32'(r.mis));
        check("resp_cycle", 32'(cyc), 32'(r.cyc));
      end
    end
  end

  // Present a request and wait for it to be accepted; exp is the load result or the word written.
  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                       input logic [31:0] wd, input bit mis, input logic [31:0] exp,
                       input bit push, output int acc_cyc);
    int budget;
    int lat;
    @(negedge clk); #1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    budget = 0;
    while (!req_ready && budget < 20) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: addr %h not accepted in 20 cycles", addr);
      req_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc;
    if (push) begin
      lat = mis ? 1 : ((wr && sz != 2'b10) ? 3 : 2);
      resp_q.push_back('{(wr || mis) ? 32'h0 : exp, mis, cyc + lat});
      if (wr && !mis) wr_q.push_back('{addr[12:2], exp});
      if (!mis && (!wr || sz != 2'b10)) exp_reads++;
    end
    @(posedge clk);
  endtask

  task automatic op(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                    input logic [31:0] wd, input bit mis, input logic [31:0] exp);
    int acc;
    issue(wr, sz, sg, addr, wd, mis, exp, 1'b1, acc);
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int a1, a2, a3, t;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    reset = 1'b1;
    #1;
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Word store and load at 0x10 (word address 4); wrapped alias 0x2010.
    op(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    op(0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF);
    op(0, 2'b10, 0, 32'h2010, 32'h0,      0, 32'hDEADBEEF);

    // Byte RMW into 0x11223344: only wdata[7:0] lands in lane 1.
    op(1, 2'b10, 0, 32'h20, 32'h11223344, 0, 32'h11223344);
    op(1, 2'b00, 0, 32'h21, 32'h123456AA, 0, 32'h1122AA44);
    op(0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h1122AA44);
    // Halfword RMW into the upper half.
    op(1, 2'b01, 0, 32'h22, 32'hCAFEBEEF, 0, 32'hBEEFAA44);
    op(0, 2'b10, 0, 32'h20, 32'h0,        0, 32'hBEEFAA44);
    op(0, 2'b00, 0, 32'h20, 32'h0,        0, 32'h00000044);
    op(0, 2'b00, 1, 32'h23, 32'h0,        0, 32'hFFFFFFBE);

    // Sign/zero extension on 0x00008000.
    op(1, 2'b10, 0, 32'h30, 32'h00008000, 0, 32'h00008000);
    op(0, 2'b01, 1, 32'h30, 32'h0,        0, 32'hFFFF8000);
    op(0, 2'b01, 0, 32'h30, 32'h0,        0, 32'h00008000);
    op(0, 2'b00, 1, 32'h33, 32'h0,        0, 32'h00000000);
    op(0, 2'b00, 1, 32'h31, 32'h0,        0, 32'hFFFFFF80);
    op(0, 2'b00, 0, 32'h31, 32'h0,        0, 32'h00000080);
    op(0, 2'b01, 1, 32'h32, 32'h0,        0, 32'h00000000);

    // Misaligned requests: rejected, no memory traffic.
    op(0, 2'b10, 0, 32'h42, 32'h0,        1, 32'h0);
    op(0, 2'b01, 1, 32'h41, 32'h0,        1, 32'h0);
    op(0, 2'b11, 0, 32'h40, 32'h0,        1, 32'h0);
    op(1, 2'b01, 0, 32'h23, 32'h0000FFFF, 1, 32'h0);

    // Reset during RMW_READ of a byte store: abort, nothing written, no response.
    issue(1, 2'b00, 0, 32'h22, 32'h00000055, 0, 32'h0, 1'b0, a1);
    #1;
    check("rmw_read_before_reset", 32'(mem_read), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_mem_wdata", mem_wdata, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    op(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'hBEEFAA44);

    // Three word loads with req_valid held high throughout.
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b1, a1);
    issue(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'hBEEFAA44, 1'b1, a2);
    issue(0, 2'b10, 0, 32'h30, 32'h0, 0, 32'h00008000, 1'b1, a3);
    @(negedge clk); #1;
    req_valid = 1'b0;
    check("b2b_spacing_1", 32'(a2 - a1), 32'd3);
    check("b2b_spacing_2", 32'(a3 - a2), 32'd3);

    t = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    #1;
    check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    check("write_queue_drained", 32'(wr_q.size()), 32'd0);
    check("mem_read_cycles", 32'(reads_seen), 32'(exp_reads));
    check("never_read_and_write", 32'(both_hi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
